// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU definitions used by the instruction fetch controller.
// Holds the fetch FSM state encoding and the zero/NOP instruction word.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/fetch_ctrl_reg.sv
// Generic parameterized register with synchronous clear (to CLR_VAL) and load.
// Clear has priority over load.
module fetch_ctrl_reg #(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = CLR_VAL;
        end else if (ld) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign q = data_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues imem requests, parks data during hazards,
// and drops in-flight fetches on branch redirects.
//
// Handshake: imem_req/imem_addr form a valid that stays stable until the memory
// answers with imem_ready (the ready); one request completes per ready cycle.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hazard,
    input  logic         branch_taken,
    input  logic [31:0]  branch_addr,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_ready,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  if_pc,
    output logic [31:0]  if_inst,
    output logic         if_freeze,
    output logic         if_flush,
    output logic [31:0]  fetch_count,
    output fetch_state_e dbg_state
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  pc_next;
    logic [31:0]  buf_q;
    logic [31:0]  count_q;
    logic [31:0]  count_d;
    logic [31:0]  drain_addr_q;
    logic [31:0]  drain_addr_d;
    logic         in_rst;
    logic         redirect;
    logic         deliver;
    logic         pc_ld;
    logic         buf_ld;

    assign pc_next  = pc_q + 32'(PC_STEP);
    // The RST state cycle behaves exactly like reset itself on the outputs.
    assign in_rst   = rst || (state_q == ST_RST);
    assign redirect = !in_rst && branch_taken;
    assign deliver  = !in_rst && !branch_taken && !hazard &&
                      (((state_q == ST_FETCH) && imem_ready) || (state_q == ST_HOLD));
    assign buf_ld   = !in_rst && !branch_taken && hazard &&
                      (state_q == ST_FETCH) && imem_ready;
    assign pc_ld    = redirect || deliver;
    assign pc_d     = redirect ? branch_addr : pc_next;

    always_comb begin
        state_d      = state_q;
        drain_addr_d = drain_addr_q;
        count_d      = count_q;
        if (deliver) begin
            count_d = count_q + 32'd1;
        end
        unique case (state_q)
            ST_RST:   state_d = ST_FETCH;
            ST_FETCH: begin
                if (branch_taken) begin
                    // Unanswered request must finish at its original address.
                    state_d      = imem_ready ? ST_FETCH : ST_DRAIN;
                    drain_addr_d = pc_q;
                end else if (imem_ready && hazard) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD:  if (branch_taken || !hazard) state_d = ST_FETCH;
            ST_DRAIN: if (imem_ready) state_d = ST_FETCH;
            default:  state_d = ST_RST;
        endcase
        if (rst) begin
            state_d      = ST_RST;
            count_d      = '0;
            drain_addr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        state_q      <= state_d;
        count_q      <= count_d;
        drain_addr_q <= drain_addr_d;
    end

    fetch_ctrl_reg #(.WIDTH(32), .CLR_VAL(RESET_PC)) u_pc_reg (
        .clk (clk),
        .clr (rst),
        .ld  (pc_ld),
        .d   (pc_d),
        .q   (pc_q)
    );

    fetch_ctrl_reg #(.WIDTH(32), .CLR_VAL(NOP_INST)) u_buf_reg (
        .clk (clk),
        .clr (rst),
        .ld  (buf_ld),
        .d   (imem_rdata),
        .q   (buf_q)
    );

    assign imem_req    = !in_rst && ((state_q == ST_FETCH) || (state_q == ST_DRAIN));
    assign imem_addr   = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
    assign if_pc       = in_rst ? 32'h0 : pc_next;
    assign if_inst     = in_rst ? NOP_INST : ((state_q == ST_HOLD) ? buf_q : imem_rdata);
    assign if_freeze   = in_rst ? 1'b1 : (redirect ? 1'b0 : !deliver);
    assign if_flush    = in_rst ? 1'b1 : redirect;
    assign fetch_count = count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, streaming, memory stalls, hazard hold,
// branch drain and reset during drain.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         hazard = 1'b0;
    logic         branch_taken = 1'b0;
    logic [31:0]  branch_addr = '0;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_ready = 1'b0;
    logic [31:0]  imem_rdata = '0;
    logic [31:0]  if_pc;
    logic [31:0]  if_inst;
    logic         if_freeze;
    logic         if_flush;
    logic [31:0]  fetch_count;
    fetch_state_e dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .hazard       (hazard),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_freeze    (if_freeze),
        .if_flush     (if_flush),
        .fetch_count  (fetch_count),
        .dbg_state    (dbg_state)
    );

    // Inputs change at the falling edge; outputs are observed 1ns later.
    task automatic drive(input logic r, input logic h, input logic b,
                         input logic [31:0] ba, input logic [31:0] rd);
        @(negedge clk);
        imem_ready = r; hazard = h; branch_taken = b; branch_addr = ba; imem_rdata = rd;
        #1;
    endtask

    // Leaves the bench 1ns into the RST-state cycle that follows reset.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; imem_ready = 1'b0; hazard = 1'b0; branch_taken = 1'b0;
        branch_addr = '0; imem_rdata = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; imem_ready = 1'b1; hazard = 1'b1; branch_taken = 1'b1;
        branch_addr = 32'h40; imem_rdata = 32'h1234_5678;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", imem_req); end
        checks++; if (if_flush !== 1'b1 || if_freeze !== 1'b1) begin errors++; $display("FAIL rst_flush_freeze: got %b%b exp 11", if_flush, if_freeze); end
        @(negedge clk);
        #1;
        checks++; if (if_pc !== 32'h0 || if_inst !== 32'h0) begin errors++; $display("FAIL rst_if: got %h %h exp 0 0", if_pc, if_inst); end
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL rst_count: got %h exp 0", fetch_count); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (dbg_state !== ST_RST) begin errors++; $display("FAIL rst_state: got %0d exp %0d", dbg_state, ST_RST); end
        checks++; if (imem_req !== 1'b0 || if_freeze !== 1'b1 || if_flush !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'h0)
            begin errors++; $display("FAIL post_rst_outputs: got req=%b frz=%b fl=%b pc=%h inst=%h", imem_req, if_freeze, if_flush, if_pc, if_inst); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 32'hA000_0000 + i);
            exp_pc = 32'(i * 4);
            checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin errors++; $display("FAIL stream_addr%0d: got %b %h exp 1 %h", i, imem_req, imem_addr, exp_pc); end
            checks++; if (if_pc !== exp_pc + 32'd4 || if_inst !== 32'hA000_0000 + i || if_freeze !== 1'b0)
                begin errors++; $display("FAIL stream_deliver%0d: got %h %h %b exp %h %h 0", i, if_pc, if_inst, if_freeze, exp_pc + 32'd4, 32'hA000_0000 + i); end
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (fetch_count !== 32'd3 || imem_addr !== 32'hC) begin errors++; $display("FAIL stream_count: got %0d %h exp 3 0000000c", fetch_count, imem_addr); end
    endtask

    task automatic test_mem_stall();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h11);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h22);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF);
            checks++; if (if_freeze !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h8)
                begin errors++; $display("FAIL stall_wait%0d: got frz=%b req=%b addr=%h exp 1 1 00000008", i, if_freeze, imem_req, imem_addr); end
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h33);
        checks++; if (if_freeze !== 1'b0 || if_pc !== 32'hC || if_inst !== 32'h33) begin errors++; $display("FAIL stall_deliver: got %b %h %h exp 0 0000000c 00000033", if_freeze, if_pc, if_inst); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (fetch_count !== 32'd3 || imem_addr !== 32'hC) begin errors++; $display("FAIL stall_single: got %0d %h exp 3 0000000c", fetch_count, imem_addr); end
    endtask

    task automatic test_hazard_hold();
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF);
        checks++; if (if_freeze !== 1'b1 || if_flush !== 1'b0) begin errors++; $display("FAIL haz_capture: got frz=%b fl=%b exp 1 0", if_freeze, if_flush); end
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h5555_5555);
        checks++; if (dbg_state !== ST_HOLD || imem_req !== 1'b0 || if_freeze !== 1'b1)
            begin errors++; $display("FAIL haz_hold: got st=%0d req=%b frz=%b exp %0d 0 1", dbg_state, imem_req, if_freeze, ST_HOLD); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h6666_6666);
        checks++; if (if_freeze !== 1'b0 || if_inst !== 32'hDEAD_BEEF || if_pc !== 32'h4)
            begin errors++; $display("FAIL haz_release: got %b %h %h exp 0 deadbeef 00000004", if_freeze, if_inst, if_pc); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || fetch_count !== 32'd1)
            begin errors++; $display("FAIL haz_resume: got %b %h %0d exp 1 00000004 1", imem_req, imem_addr, fetch_count); end
    endtask

    task automatic test_branch_drain();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h11);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h22);
        drive(1'b0, 1'b0, 1'b1, 32'h100, 32'h0);
        checks++; if (if_flush !== 1'b1 || if_freeze !== 1'b0) begin errors++; $display("FAIL br_flush: got fl=%b frz=%b exp 1 0", if_flush, if_freeze); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || if_flush !== 1'b0 || if_freeze !== 1'b1)
            begin errors++; $display("FAIL br_drain_hold: got req=%b addr=%h fl=%b frz=%b exp 1 00000008 0 1", imem_req, imem_addr, if_flush, if_freeze); end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'hBAD0_BAD0);
        checks++; if (if_freeze !== 1'b1 || if_flush !== 1'b0) begin errors++; $display("FAIL br_discard: got frz=%b fl=%b exp 1 0", if_freeze, if_flush); end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h77);
        checks++; if (imem_addr !== 32'h100 || if_pc !== 32'h104 || if_inst !== 32'h77 || if_freeze !== 1'b0)
            begin errors++; $display("FAIL br_target: got %h %h %h %b exp 00000100 00000104 00000077 0", imem_addr, if_pc, if_inst, if_freeze); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL br_count: got %0d exp 3", fetch_count); end
    endtask

    task automatic test_branch_over_hazard();
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hCAFE_0001);
        drive(1'b0, 1'b1, 1'b1, 32'h200, 32'h0);
        checks++; if (if_flush !== 1'b1 || if_freeze !== 1'b0) begin errors++; $display("FAIL bh_flush: got fl=%b frz=%b exp 1 0", if_flush, if_freeze); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (imem_addr !== 32'h200 || imem_req !== 1'b1 || fetch_count !== 32'd0)
            begin errors++; $display("FAIL bh_target: got %h %b %0d exp 00000200 1 0", imem_addr, imem_req, fetch_count); end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h99);
        checks++; if (if_inst !== 32'h99 || if_pc !== 32'h204) begin errors++; $display("FAIL bh_deliver: got %h %h exp 00000099 00000204", if_inst, if_pc); end
    endtask

    task automatic test_reset_in_drain();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h11);
        drive(1'b0, 1'b0, 1'b1, 32'h300, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (dbg_state !== ST_DRAIN) begin errors++; $display("FAIL rd_in_drain: got %0d exp %0d", dbg_state, ST_DRAIN); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hBAD1_BAD1;
        #1;
        checks++; if (if_freeze !== 1'b1 || imem_req !== 1'b0 || fetch_count !== 32'd0)
            begin errors++; $display("FAIL rd_stale: got frz=%b req=%b cnt=%0d exp 1 0 0", if_freeze, imem_req, fetch_count); end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h44);
        checks++; if (imem_addr !== 32'h0 || if_pc !== 32'h4 || if_inst !== 32'h44)
            begin errors++; $display("FAIL rd_refetch: got %h %h %h exp 00000000 00000004 00000044", imem_addr, if_pc, if_inst); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_mem_stall();
        test_hazard_hold();
        test_branch_drain();
        test_branch_over_hazard();
        test_reset_in_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 4, PC increment per delivered instruction.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 hazard  input  1  hazard-unit stall request; no new instruction may enter the IF register.
REQ-006 branch_taken  input  1  redirect request from the execute stage.
REQ-007 branch_addr  input  32  redirect target, valid when branch_taken=1.
REQ-008 imem_req  output  1  instruction-memory request.
REQ-009 imem_addr  output  32  request address.
REQ-010 imem_ready  input  1  memory completes the current request this cycle.
REQ-011 imem_rdata  input  32  instruction word, valid when imem_ready=1.
REQ-012 if_pc  output  32  PC+PC_STEP of the delivered instruction, to the IF stage register.
REQ-013 if_inst  output  32  delivered instruction, to the IF stage register.
REQ-014 if_freeze  output  1  IF stage register hold (load enable = ~if_freeze).
REQ-015 if_flush  output  1  IF stage register clear.
REQ-016 fetch_count  output  32  count of delivered instructions.

Function
REQ-017 States: RST, FETCH, HOLD, DRAIN; RST SHALL go to FETCH unconditionally after one cycle.
REQ-018 Deliver event: (FETCH & imem_ready & ~hazard & ~branch_taken) or (HOLD & ~hazard & ~branch_taken).
REQ-019 On deliver: if_freeze=0; if_inst = imem_rdata (FETCH) or hold buffer (HOLD); if_pc = pc+PC_STEP; pc <= pc+PC_STEP; fetch_count += 1 (wraps mod 2^32).
REQ-020 In every non-deliver, non-branch cycle, if_freeze SHALL be 1 and if_flush 0.
REQ-021 FETCH: imem_req=1, imem_addr=pc; once asserted, imem_req and imem_addr SHALL stay stable until imem_ready.
REQ-022 FETCH & imem_ready & hazard & ~branch_taken: capture imem_rdata into hold buffer and go to HOLD; imem_req=0 in HOLD.
REQ-023 HOLD & ~hazard: deliver the buffer and return to FETCH; zero-bubble latency after hazard drops.
REQ-024 branch_taken (any non-RST state) has priority over hazard and deliver: if_flush=1, if_freeze=0, pc <= branch_addr, no delivery, fetch_count unchanged.
REQ-025 Branch in FETCH without imem_ready: go to DRAIN; the outstanding request keeps its original address until imem_ready, then its data is discarded and the state goes to FETCH.
REQ-026 Branch in FETCH with imem_ready, or in HOLD: discard the data/buffer and go to FETCH.
REQ-027 Branch in DRAIN: update pc, flush again, stay in DRAIN; DRAIN & imem_ready & branch_taken goes to FETCH.
REQ-028 Memory latency of 0..N cycles SHALL be tolerated without loss or duplication; back-to-back delivery at 1 per cycle when imem_ready stays high.

Reset
REQ-029 rst (any state, mid-transaction included) SHALL set pc=RESET_PC, state=RST, fetch_count=0, hold buffer=0.
REQ-030 During and one cycle after reset: imem_req=0, if_freeze=1, if_flush=1, if_pc=0, if_inst=0.
REQ-031 rst has priority over branch_taken and hazard.

Structure
REQ-032 State encoding and the NOP/zero instruction constant SHALL live in the shared CPU package.
REQ-033 PC and hold buffer SHALL use the existing generic parameterized register module (ld, clr); no other sub-module.

Verification
REQ-034 Reset, imem_ready=1 constantly -> imem_addr 0,4,8; if_pc 4,8,12; fetch_count=3 after 3 deliveries.
REQ-035 imem_ready 3 cycles late -> if_freeze=1 for 3 cycles, imem_addr held at 0x8, a single delivery with if_pc=0xC.
REQ-036 hazard high 2 cycles while imem_ready returns 0xDEADBEEF -> HOLD, imem_req=0; delivery of 0xDEADBEEF the cycle hazard falls.
REQ-037 branch_taken to 0x100 with request at 0x8 pending -> if_flush=1 one cycle; 0x8 data discarded on ready; next imem_addr=0x100; if_pc=0x104.
REQ-038 branch_taken and hazard together in HOLD -> flush wins, buffer dropped, fetch at target, fetch_count unchanged.
REQ-039 rst asserted mid-DRAIN -> next imem_addr=RESET_PC, stale ready ignored, fetch_count=0.
